// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM request responder and the SDRAM address calculator.
package sdram_resp_pkg;

  localparam int unsigned SDRAM_ADDR_W  = 24;
  localparam int unsigned SDRAM_DATA_W  = 32;
  localparam int unsigned SDRAM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/sdram_responder_timeout_counter.sv
// Saturating cycle counter that flags when an outstanding transaction has run too long.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // Asserted on the TIMEOUT-th busy edge, so the abort edge lands TIMEOUT cycles after entry.
  assign expired = (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_responder.sv
// Control-unit facing responder: turns read/write pulses into one Avalon-MM transaction
// with registered completion pulses, sticky error flags and a timeout abort.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = SDRAM_ADDR_W,
  parameter int unsigned DATA_W  = SDRAM_DATA_W,
  parameter int unsigned TIMEOUT = SDRAM_TIMEOUT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              dataRead,
  output logic [DATA_W-1:0] read_data,
  output logic              write_done,
  output logic              busy,
  output logic              protocol_err,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  resp_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic              rd_d, wr_d, data_read_d, write_done_d;
  logic              perr_d, terr_d;
  logic              cnt_clear, expired;

  timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (cnt_clear),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      read_data     <= '0;
      dataRead      <= 1'b0;
      write_done    <= 1'b0;
      protocol_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy          <= (state_d != IDLE);
      avm_address   <= addr_d;
      avm_read      <= rd_d;
      avm_write     <= wr_d;
      avm_writedata <= wdata_d;
      read_data     <= rdata_d;
      dataRead      <= data_read_d;
      write_done    <= write_done_d;
      protocol_err  <= perr_d;
      timeout_err   <= terr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = avm_address;
    rd_d         = avm_read;
    wr_d         = avm_write;
    wdata_d      = avm_writedata;
    rdata_d      = read_data;
    data_read_d  = 1'b0;
    write_done_d = 1'b0;
    perr_d       = protocol_err;
    terr_d       = timeout_err;
    cnt_clear    = 1'b0;

    if ((state_q != IDLE) && (read_en || write_en)) begin
      perr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (read_en) begin
          addr_d    = address;
          rd_d      = 1'b1;
          cnt_clear = 1'b1;
          state_d   = RD_REQ;
          if (write_en) begin
            perr_d = 1'b1;
          end
        end else if (write_en) begin
          addr_d    = address;
          wdata_d   = write_data;
          wr_d      = 1'b1;
          cnt_clear = 1'b1;
          state_d   = WR_REQ;
        end
      end

      RD_REQ: begin
        // Data arriving on the acceptance edge completes the read without visiting RD_WAIT.
        if (!avm_waitrequest && avm_readdatavalid) begin
          rd_d        = 1'b0;
          rdata_d     = avm_readdata;
          data_read_d = 1'b1;
          state_d     = IDLE;
        end else if (expired) begin
          rd_d        = 1'b0;
          rdata_d     = '0;
          data_read_d = 1'b1;
          terr_d      = 1'b1;
          state_d     = IDLE;
        end else if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d     = avm_readdata;
          data_read_d = 1'b1;
          state_d     = IDLE;
        end else if (expired) begin
          rdata_d     = '0;
          data_read_d = 1'b1;
          terr_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      WR_REQ: begin
        if (!avm_waitrequest) begin
          wr_d         = 1'b0;
          write_done_d = 1'b1;
          state_d      = IDLE;
        end else if (expired) begin
          wr_d         = 1'b0;
          write_done_d = 1'b1;
          terr_d       = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder with a scripted Avalon-MM memory.
module tb_sdram_responder;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          n_rst;
  logic          read_en, write_en;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          dataRead, write_done, busy, protocol_err, timeout_err;
  logic [DW-1:0] read_data;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    rd_exp_q[$];
  logic [AW+DW-1:0] wr_exp_q[$];

  sdram_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(8)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .read_en          (read_en),
    .write_en         (write_en),
    .address          (address),
    .write_data       (write_data),
    .dataRead         (dataRead),
    .read_data        (read_data),
    .write_done       (write_done),
    .busy             (busy),
    .protocol_err     (protocol_err),
    .timeout_err      (timeout_err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read and play the memory side; reports what was observed on both ports.
  task automatic do_read(input logic [AW-1:0] addr, input logic also_write, input int stall,
                         input int rdv_cyc, input int extra_rd_cyc, input logic [DW-1:0] rdata,
                         output int rd_cycles, output int wr_cycles, output int pulses,
                         output int pulse_cyc, output logic [DW-1:0] got, output logic addr_ok);
    rd_cycles = 0; wr_cycles = 0; pulses = 0; pulse_cyc = -1; got = '0; addr_ok = 1'b1;
    read_en = 1'b1; write_en = also_write; address = addr; write_data = 32'hBAD0BAD0;
    tick();
    read_en = 1'b0; write_en = 1'b0; address = ~addr;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (avm_read) begin
        rd_cycles++;
        if (avm_address !== addr) addr_ok = 1'b0;
      end
      if (avm_write) wr_cycles++;
      if (dataRead) begin
        pulses++;
        pulse_cyc = cyc;
        got = read_data;
      end
      read_en           = (cyc == extra_rd_cyc);
      avm_waitrequest   = (cyc < stall);
      avm_readdatavalid = (cyc == rdv_cyc);
      avm_readdata      = (cyc == rdv_cyc) ? rdata : ~rdata;
      tick();
    end
    read_en = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int stall,
                          output int wr_cycles, output int pulses, output int done_cyc,
                          output logic stable_ok, output logic accepted,
                          output logic [AW+DW-1:0] acc);
    wr_cycles = 0; pulses = 0; done_cyc = -1; stable_ok = 1'b1; accepted = 1'b0; acc = '0;
    write_en = 1'b1; address = addr; write_data = data;
    tick();
    write_en = 1'b0; address = ~addr; write_data = ~data;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (avm_write) begin
        wr_cycles++;
        if (avm_address !== addr || avm_writedata !== data) stable_ok = 1'b0;
      end
      if (write_done) begin
        pulses++;
        done_cyc = cyc;
      end
      avm_waitrequest = (cyc < stall);
      if (avm_write && !avm_waitrequest) begin
        accepted = 1'b1;
        acc = {avm_address, avm_writedata};
      end
      tick();
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; read_en = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    #12;
    checks++;
    if ({busy, dataRead, write_done, avm_read, avm_write} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, dataRead, write_done, avm_read, avm_write});
    end
    checks++;
    if ({protocol_err, timeout_err} !== 2'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {protocol_err, timeout_err});
    end
    checks++;
    if (read_data !== '0 || avm_address !== '0 || avm_writedata !== '0) begin
      errors++; $display("FAIL reset_data: rd=%h addr=%h wd=%h expected zeros", read_data, avm_address, avm_writedata);
    end
    #5 n_rst = 1'b1;
    tick();
  endtask

  task automatic test_read_basic();
    int rc, wc, p, pc; logic [DW-1:0] got; logic aok; logic [DW-1:0] exp;
    rd_exp_q.push_back(32'hDEADBEEF);
    do_read(24'h00ABCD, 1'b0, 0, 3, -1, 32'hDEADBEEF, rc, wc, p, pc, got, aok);
    checks++;
    if (rc != 1 || !aok) begin errors++; $display("FAIL rd_cmd: avm_read cycles=%0d addr_ok=%0d expected 1/1", rc, aok); end
    checks++;
    if (p != 1 || pc != 4) begin errors++; $display("FAIL rd_pulse: pulses=%0d at cyc %0d expected 1 at 4", p, pc); end
    exp = rd_exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_data: got %h expected %h", got, exp); end
    checks++;
    if (read_data !== exp || busy !== 1'b0) begin
      errors++; $display("FAIL rd_hold: read_data=%h busy=%b expected %h/0", read_data, busy, exp);
    end
  endtask

  task automatic test_write_stall();
    int wc, p, dc; logic ok, accd; logic [AW+DW-1:0] acc, exp;
    wr_exp_q.push_back({24'h000100, 32'h12345678});
    do_write(24'h000100, 32'h12345678, 4, wc, p, dc, ok, accd, acc);
    checks++;
    if (wc != 5 || !ok) begin errors++; $display("FAIL wr_stable: avm_write cycles=%0d stable=%0d expected 5/1", wc, ok); end
    checks++;
    if (p != 1 || dc != 5) begin errors++; $display("FAIL wr_done: pulses=%0d at cyc %0d expected 1 at 5", p, dc); end
    exp = wr_exp_q.pop_front();
    checks++;
    if (!accd || acc !== exp) begin errors++; $display("FAIL wr_accept: got %h (acc=%0d) expected %h", acc, accd, exp); end
  endtask

  task automatic test_same_edge();
    int rc, wc, p, pc; logic [DW-1:0] got; logic aok; logic [DW-1:0] exp;
    rd_exp_q.push_back(32'hCAFEF00D);
    do_read(24'h123456, 1'b0, 2, 2, -1, 32'hCAFEF00D, rc, wc, p, pc, got, aok);
    exp = rd_exp_q.pop_front();
    checks++;
    if (rc != 3 || !aok) begin errors++; $display("FAIL se_cmd: avm_read cycles=%0d addr_ok=%0d expected 3/1", rc, aok); end
    checks++;
    if (p != 1 || pc != 3 || got !== exp) begin
      errors++; $display("FAIL se_pulse: pulses=%0d cyc=%0d data=%h expected 1/3/%h", p, pc, got, exp);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL se_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_conflict();
    int rc, wc, p, pc; logic [DW-1:0] got; logic aok; logic [DW-1:0] exp;
    checks++;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL pe_pre: protocol_err=%b expected 0", protocol_err); end
    rd_exp_q.push_back(32'h0BADF00D);
    do_read(24'h00F00F, 1'b1, 0, 2, 0, 32'h0BADF00D, rc, wc, p, pc, got, aok);
    exp = rd_exp_q.pop_front();
    checks++;
    if (rc != 1 || wc != 0 || !aok) begin
      errors++; $display("FAIL pe_port: reads=%0d writes=%0d addr_ok=%0d expected 1/0/1", rc, wc, aok);
    end
    checks++;
    if (p != 1 || got !== exp) begin errors++; $display("FAIL pe_data: pulses=%0d data=%h expected 1/%h", p, got, exp); end
    checks++;
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL pe_flag: protocol_err=%b expected 1", protocol_err); end
  endtask

  task automatic test_timeout();
    int rc, wc, p, pc, dc; logic [DW-1:0] got; logic aok, ok, accd; logic [AW+DW-1:0] acc;
    logic [DW-1:0] exp;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre: timeout_err=%b expected 0", timeout_err); end
    rd_exp_q.push_back(32'h0);
    do_read(24'h000777, 1'b0, 0, -1, -1, 32'h55AA55AA, rc, wc, p, pc, got, aok);
    exp = rd_exp_q.pop_front();
    checks++;
    if (p != 1 || pc != 8 || got !== exp) begin
      errors++; $display("FAIL to_rd: pulses=%0d cyc=%0d data=%h expected 1/8/%h", p, pc, got, exp);
    end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_flag: timeout_err=%b busy=%b expected 1/0", timeout_err, busy);
    end
    rd_exp_q.push_back(32'hA5A5F0F0);
    do_read(24'h000888, 1'b0, 0, 1, -1, 32'hA5A5F0F0, rc, wc, p, pc, got, aok);
    exp = rd_exp_q.pop_front();
    checks++;
    if (p != 1 || pc != 2 || got !== exp) begin
      errors++; $display("FAIL to_next: pulses=%0d cyc=%0d data=%h expected 1/2/%h", p, pc, got, exp);
    end
    do_write(24'h000999, 32'h13572468, 30, wc, p, dc, ok, accd, acc);
    checks++;
    if (wc != 8 || p != 1 || dc != 8 || accd) begin
      errors++; $display("FAIL to_wr: writes=%0d pulses=%0d cyc=%0d acc=%0d expected 8/1/8/0", wc, p, dc, accd);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    read_en = 1'b1; address = 24'h00C0DE;
    tick();
    read_en = 1'b0; avm_waitrequest = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || avm_address !== 24'h00C0DE) begin
      errors++; $display("FAIL rm_pre: busy=%b addr=%h expected 1/00c0de", busy, avm_address);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, avm_read, avm_write} !== 3'b0 || avm_address !== '0 || avm_writedata !== '0) begin
      errors++; $display("FAIL rm_drop: busy/rd/wr=%b addr=%h wd=%h expected zeros",
                         {busy, avm_read, avm_write}, avm_address, avm_writedata);
    end
    checks++;
    if ({protocol_err, timeout_err} !== 2'b0 || read_data !== '0) begin
      errors++; $display("FAIL rm_flags: flags=%b read_data=%h expected 00/0", {protocol_err, timeout_err}, read_data);
    end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h77777777;
    for (int i = 0; i < 6; i++) begin
      if (dataRead) pulses++;
      if (i == 2) n_rst = 1'b1;
      tick();
    end
    avm_readdatavalid = 1'b0;
    checks++;
    if (pulses != 0 || dataRead !== 1'b0 || protocol_err !== 1'b0) begin
      errors++; $display("FAIL rm_nopulse: pulses=%0d protocol_err=%b expected 0/0", pulses, protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_same_edge();
    test_conflict();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
